// File: rtl/display_sr_receiver_pkg.sv
// display_sr_receiver_pkg: segment codes, BCD markers and receiver FSM states
package display_sr_receiver_pkg;
  typedef enum logic [1:0] {IDLE, RECV, OVER} state_e;
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [3:0] BCD_BLANK = 4'hE;
  localparam logic [3:0] BCD_INVALID = 4'hF;
endpackage

// File: rtl/display_sr_receiver_seg7_to_bcd.sv
// display_sr_receiver_seg7_to_bcd: combinational 7-segment pattern to BCD decoder
//   seg_i [6:0] segments {g,f,e,d,c,b,a}; bcd_o digit, E for blank, F if invalid; err_o invalid flag
module display_sr_receiver_seg7_to_bcd
  import display_sr_receiver_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       err_o
);
  always_comb begin
    bcd_o = BCD_INVALID;
    err_o = 1'b0;
    case (seg_i)
      SEG_0: bcd_o = 4'd0;
      SEG_1: bcd_o = 4'd1;
      SEG_2: bcd_o = 4'd2;
      SEG_3: bcd_o = 4'd3;
      SEG_4: bcd_o = 4'd4;
      SEG_5: bcd_o = 4'd5;
      SEG_6: bcd_o = 4'd6;
      SEG_7: bcd_o = 4'd7;
      SEG_8: bcd_o = 4'd8;
      SEG_9: bcd_o = 4'd9;
      SEG_BLANK: bcd_o = BCD_BLANK;
      default: err_o = 1'b1;
    endcase
  end
endmodule

// File: rtl/display_sr_receiver.sv
// display_sr_receiver: oversampling serial-to-parallel receiver for the 7-segment shift-register link
//   clk_i/reset_n_i   oversampling clock, async active-low reset (released synchronously)
//   sr_data_i/sr_clk_i/sr_latch_i  asynchronous link pins
//   segments_o/bcd_o/decode_err_o  latched frame and its per-digit decode
//   frame_valid_o/frame_error_o    one-clock pulses on a good / malformed latch
//   bit_count_o       bits shifted since last latch, saturating at FRAME_BITS+1
module display_sr_receiver
  import display_sr_receiver_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int SYNC_STAGES = 2,
  localparam int FRAME_BITS = 8 * NUM_DIGITS,
  localparam int CW = $clog2(FRAME_BITS + 2)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    sr_data_i,
  input  logic                    sr_clk_i,
  input  logic                    sr_latch_i,
  output logic [FRAME_BITS-1:0]   segments_o,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic                    frame_valid_o,
  output logic                    frame_error_o,
  output logic [NUM_DIGITS-1:0]   decode_err_o,
  output logic [CW-1:0]           bit_count_o
);
  localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);
  localparam logic [CW-1:0] SAT = CW'(FRAME_BITS + 1);
  logic rst_meta_q, rst_n_q;
  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q, lat_sync_q;
  logic clk_prev_q, lat_prev_q, clk_rise_q, lat_rise_q, dat_q;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_after;
  logic [FRAME_BITS-1:0] chain_q, chain_d, seg_q, seg_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d, bcd_w;
  logic [NUM_DIGITS-1:0] derr_q, derr_d, err_w;
  logic fv_q, fv_d, fe_q, fe_d, ignore;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rst_meta_q <= 1'b0;
      rst_n_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q <= rst_meta_q;
    end
  end

  // Data passes through the same depth as sr_clk so dat_q lines up with clk_rise_q.
  always_ff @(posedge clk_i or negedge rst_n_q) begin
    if (!rst_n_q) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      lat_sync_q <= '0;
      clk_prev_q <= 1'b0;
      lat_prev_q <= 1'b0;
      clk_rise_q <= 1'b0;
      lat_rise_q <= 1'b0;
      dat_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], sr_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], sr_data_i};
      lat_sync_q <= {lat_sync_q[SYNC_STAGES-2:0], sr_latch_i};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
      lat_prev_q <= lat_sync_q[SYNC_STAGES-1];
      clk_rise_q <= clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
      lat_rise_q <= lat_sync_q[SYNC_STAGES-1] & ~lat_prev_q;
      dat_q <= dat_sync_q[SYNC_STAGES-1];
    end
  end

  // The decoders look at the post-shift chain so a shift coinciding with the latch is included.
  assign chain_d = clk_rise_q ? {chain_q[FRAME_BITS-2:0], dat_q} : chain_q;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    display_sr_receiver_seg7_to_bcd u_dec (
      .seg_i(chain_d[8*k +: 7]),
      .bcd_o(bcd_w[4*k +: 4]),
      .err_o(err_w[k])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    seg_d = seg_q;
    bcd_d = bcd_q;
    derr_d = derr_q;
    fv_d = 1'b0;
    fe_d = 1'b0;
    cnt_after = !clk_rise_q ? cnt_q : state_q == IDLE ? CW'(1) : state_q == OVER ? cnt_q : cnt_q + 1'b1;
    ignore = state_q == IDLE && !clk_rise_q;
    if (lat_rise_q && !ignore) begin
      state_d = IDLE;
      cnt_d = '0;
      fv_d = cnt_after == FULL;
      fe_d = cnt_after != FULL;
      seg_d = fv_d ? chain_d : seg_q;
      bcd_d = fv_d ? bcd_w : bcd_q;
      derr_d = fv_d ? err_w : derr_q;
    end else if (clk_rise_q) begin
      cnt_d = cnt_after;
      state_d = cnt_after == SAT ? OVER : RECV;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q <= IDLE;
      cnt_q <= '0;
      chain_q <= '0;
      seg_q <= '0;
      bcd_q <= '0;
      derr_q <= '0;
      fv_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      chain_q <= chain_d;
      seg_q <= seg_d;
      bcd_q <= bcd_d;
      derr_q <= derr_d;
      fv_q <= fv_d;
      fe_q <= fe_d;
    end
  end

  assign segments_o = seg_q;
  assign bcd_o = bcd_q;
  assign decode_err_o = derr_q;
  assign frame_valid_o = fv_q;
  assign frame_error_o = fe_q;
  assign bit_count_o = cnt_q;
endmodule

// File: tb/tb_display_sr_receiver.sv
// tb_display_sr_receiver: scoreboard bench for display_sr_receiver
module tb_display_sr_receiver;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sr_data = 1'b0;
  logic sr_clk = 1'b0;
  logic sr_latch = 1'b0;
  logic [47:0] segments;
  logic [23:0] bcd;
  logic frame_valid, frame_error;
  logic [5:0] decode_err;
  logic [5:0] bit_count;

  display_sr_receiver dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .sr_data_i(sr_data),
    .sr_clk_i(sr_clk),
    .sr_latch_i(sr_latch),
    .segments_o(segments),
    .bcd_o(bcd),
    .frame_valid_o(frame_valid),
    .frame_error_o(frame_error),
    .decode_err_o(decode_err),
    .bit_count_o(bit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ok;
    logic [47:0] seg;
    logic [23:0] bcd;
    logic [5:0] err;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic [47:0] cur_seg = '0;
  logic [23:0] cur_bcd = '0;
  logic [5:0] cur_err = '0;

  always @(negedge clk) begin
    if (frame_valid || frame_error) begin
      pulses++;
      total++;
      if (frame_valid && frame_error) begin
        bad++;
        $display("FAIL both_pulses fv=%0b fe=%0b required one", frame_valid, frame_error);
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse fv=%0b fe=%0b", frame_valid, frame_error);
      end else begin
        me = sb.pop_front();
        if ({frame_valid, segments, bcd, decode_err} !== {me.ok, me.seg, me.bcd, me.err}) begin
          bad++;
          $display("FAIL frame got fv=%0b seg=%h bcd=%h err=%b want fv=%0b seg=%h bcd=%h err=%b",
                   frame_valid, segments, bcd, decode_err, me.ok, me.seg, me.bcd, me.err);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input logic with_latch);
    sr_data = b;
    sr_clk = 1'b0;
    tick(2);
    sr_clk = 1'b1;
    if (with_latch) sr_latch = 1'b1;
    tick(2);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input logic last_latch);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i], last_latch && i == 0);
  endtask

  task automatic latch();
    sr_clk = 1'b0;
    sr_latch = 1'b1;
    tick(2);
    sr_latch = 1'b0;
    tick(6);
  endtask

  task automatic push_valid(input logic [47:0] s, input logic [23:0] b, input logic [5:0] e);
    sb.push_back('{1'b1, s, b, e});
    cur_seg = s;
    cur_bcd = b;
    cur_err = e;
  endtask

  task automatic push_error();
    sb.push_back('{1'b0, cur_seg, cur_bcd, cur_err});
  endtask

  task automatic check_cnt(input string name, input logic [5:0] want);
    total++;
    if (bit_count !== want) begin
      bad++;
      $display("FAIL %s bit_count=%0d want %0d", name, bit_count, want);
    end
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({segments, bcd, decode_err, bit_count, frame_valid, frame_error} !== '0) begin
      bad++;
      $display("FAIL %s seg=%h bcd=%h err=%b cnt=%0d fv=%0b fe=%0b want all 0",
               name, segments, bcd, decode_err, bit_count, frame_valid, frame_error);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    check_zero("reset_hold");
    reset_n = 1'b1;
    tick(4);
    check_zero("reset_release");
  endtask

  task automatic test_frame();
    int lat;
    lat = 0;
    push_valid(48'h065B4F666D7D, 24'h123456, 6'b0);
    send_bits({16'h0, 48'h065B4F666D7D}, 48, 1'b0);
    tick(3);
    check_cnt("cnt_48", 6'd48);
    sr_clk = 1'b0;
    sr_latch = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (frame_valid && lat == 0) lat = i;
    end
    sr_latch = 1'b0;
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL latch_latency got %0d clk want 4", lat);
    end
    check_cnt("cnt_after_latch", 6'd0);
  endtask

  task automatic test_short();
    push_error();
    send_bits({16'h0, 48'hABCDEF123456}, 47, 1'b0);
    latch();
    push_valid(48'h6F7F077D6D66, 24'h987654, 6'b0);
    send_bits({16'h0, 48'h6F7F077D6D66}, 48, 1'b0);
    latch();
  endtask

  task automatic test_over();
    push_error();
    send_bits(64'h0003_5A5A_A5A5_1234, 50, 1'b0);
    tick(3);
    check_cnt("cnt_saturate", 6'd49);
    latch();
    check_cnt("cnt_over_cleared", 6'd0);
  endtask

  task automatic test_decode();
    push_valid(48'h3F4900077FEF, 24'h0FE789, 6'b010000);
    send_bits({16'h0, 48'h3F4900077FEF}, 48, 1'b0);
    latch();
  endtask

  task automatic test_edges();
    int p0;
    p0 = pulses;
    latch();
    total++;
    if (pulses != p0) begin
      bad++;
      $display("FAIL empty_latch pulses=%0d want %0d", pulses - p0, 0);
    end
    push_valid(48'h3F065B4F666D, 24'h012345, 6'b0);
    send_bits({16'h0, 48'h3F065B4F666D}, 48, 1'b1);
    sr_latch = 1'b0;
    sr_clk = 1'b0;
    tick(8);
    check_cnt("cnt_coincident", 6'd0);
  endtask

  task automatic test_reset_mid();
    send_bits(64'h000F_0F0F, 20, 1'b0);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero("reset_mid");
    sr_clk = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(4);
    check_zero("reset_mid_release");
    push_valid(48'h065B4F666D7D, 24'h123456, 6'b0);
    send_bits({16'h0, 48'h065B4F666D7D}, 48, 1'b0);
    latch();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_short();
    test_over();
    test_decode();
    test_edges();
    test_reset_mid();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(1);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses outstanding=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
